// File: rtl/arcade_pkg.sv
// arcade_pkg: shared court geometry and the paddle FSM state type
package arcade_pkg;
  localparam int COURT_TOP = 165;
  localparam int COURT_BOT = 434;
  localparam int POS_W     = 11;
  typedef enum logic [2:0] {IDLE, UP_SLOW, UP_FAST, DN_SLOW, DN_FAST} paddle_state_t;
endpackage

// File: rtl/paddle_clamp.sv
// paddle_clamp: one step of a position toward a wall, saturating at the wall and flagging the hit
module paddle_clamp
  import arcade_pkg::*;
#(
  parameter int LO = COURT_TOP,
  parameter int HI = COURT_BOT - 60
) (
  input  logic [POS_W-1:0] pos,
  input  logic [POS_W-1:0] step,
  input  logic             dir,
  output logic [POS_W-1:0] pos_n,
  output logic             hit_limit
);
  localparam logic [POS_W:0] LO_W = (POS_W+1)'(LO);
  localparam logic [POS_W:0] HI_W = (POS_W+1)'(HI);
  logic [POS_W:0] inc, dec;
  assign inc = {1'b0, pos} + {1'b0, step};
  assign dec = {1'b0, pos} - {1'b0, step};
  // reaching the wall exactly also counts as a hit so speed is dropped there
  assign hit_limit = dir ? inc >= HI_W : {1'b0, pos} <= LO_W + {1'b0, step};
  assign pos_n = POS_W'(hit_limit ? (dir ? HI_W : LO_W) : (dir ? inc : dec));
endmodule

// File: rtl/paddle_position_ctrl.sv
// paddle_position_ctrl: per-player paddle position, clamped to the court, with slow/fast step FSM
// PADDLE_ACCEL_EN enables the FAST states and the hold counter.
module paddle_position_ctrl
  import arcade_pkg::*;
#(
  parameter int TOP_LIMIT = COURT_TOP,
  parameter int BOT_LIMIT = COURT_BOT,
  parameter int PADDLE_H  = 60,
  parameter int RESET_POS = 270,
  parameter int SLOW_STEP = 2
`ifdef PADDLE_ACCEL_EN
  ,
  parameter int FAST_STEP  = 5,
  parameter int HOLD_TICKS = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic             move_up,
  input  logic             move_down,
  input  logic             recenter,
  output logic [POS_W-1:0] p_upper,
  output logic [POS_W-1:0] p_lower,
  output logic             at_top,
  output logic             at_bottom,
  output logic             moving
);
  paddle_state_t state, state_n;
  logic [POS_W-1:0] step, nxt;
  logic up, dn, hit;
  assign up = move_up & ~move_down;
  assign dn = move_down & ~move_up;
  paddle_clamp #(.LO(TOP_LIMIT), .HI(BOT_LIMIT - PADDLE_H)) u_clamp (
    .pos(p_upper), .step(step), .dir(dn), .pos_n(nxt), .hit_limit(hit)
  );
`ifdef PADDLE_ACCEL_EN
  localparam int HW = $clog2(HOLD_TICKS) + 1;
  localparam logic [HW-1:0] HMAX = HW'(HOLD_TICKS - 1);
  logic [HW-1:0] hold, hold_n;
  logic same;
  assign same = up ? (state == UP_SLOW || state == UP_FAST) : (state == DN_SLOW || state == DN_FAST);
  // fast speed only carries over while the request keeps the same direction
  assign step = POS_W'(((state == UP_FAST || state == DN_FAST) && same) ? FAST_STEP : SLOW_STEP);
  always_comb begin
    hold_n = (!(up | dn) || hit || !same) ? '0 : (hold == HMAX) ? hold : hold + 1'b1;
    state_n = (!(up | dn) || hit) ? IDLE : (hold_n == HMAX) ? (up ? UP_FAST : DN_FAST) : (up ? UP_SLOW : DN_SLOW);
  end
  always_ff @(posedge clk)
    if (!rst || recenter) hold <= '0;
    else if (frame_tick) hold <= hold_n;
`else
  assign step = POS_W'(SLOW_STEP);
  always_comb begin
    state_n = (!(up | dn) || hit) ? IDLE : up ? UP_SLOW : DN_SLOW;
  end
`endif
  always_ff @(posedge clk)
    if (!rst || recenter) begin
      state   <= IDLE;
      p_upper <= POS_W'(RESET_POS);
    end else if (frame_tick) begin
      state   <= state_n;
      p_upper <= (up | dn) ? nxt : p_upper;
    end
  assign p_lower   = p_upper + POS_W'(PADDLE_H);
  assign at_top    = p_upper == POS_W'(TOP_LIMIT);
  assign at_bottom = p_lower == POS_W'(BOT_LIMIT);
  assign moving    = state != IDLE;
endmodule

// File: tb/tb_paddle_position_ctrl.sv
// tb_paddle_position_ctrl: directed stimulus against a run-length paddle model plus literal expectations
module tb_paddle_position_ctrl;
`ifdef PADDLE_ACCEL_EN
  localparam bit ACCEL = 1'b1;
`else
  localparam bit ACCEL = 1'b0;
`endif
  logic clk = 0, rst = 0, frame_tick = 0, move_up = 0, move_down = 0, recenter = 0;
  logic [10:0] p_upper, p_lower;
  logic at_top, at_bottom, moving;
  int tests = 0, fails = 0;
  int m_pos = 270, m_run = 0, m_dir = 0, d, stp, tgt, n;
  bit started = 0;
  int dn_acc[12] = '{272, 274, 276, 278, 280, 282, 284, 286, 291, 296, 301, 306};

  always #5 clk = ~clk;

  paddle_position_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .move_up(move_up), .move_down(move_down),
    .recenter(recenter), .p_upper(p_upper), .p_lower(p_lower), .at_top(at_top),
    .at_bottom(at_bottom), .moving(moving)
  );

  // model: m_run counts consecutive unclamped moves in direction m_dir
  always @(posedge clk) begin
    if (!rst || recenter) begin
      m_pos = 270;
      m_run = 0;
    end else if (frame_tick) begin
      d = (move_up && !move_down) ? -1 : (move_down && !move_up) ? 1 : 0;
      if (d == 0 || d != m_dir) m_run = 0;
      if (d != 0) begin
        stp = (ACCEL && m_run >= 8) ? 5 : 2;
        tgt = m_pos + d * stp;
        if (tgt <= 165 || tgt >= 374) begin
          m_pos = (tgt <= 165) ? 165 : 374;
          m_run = 0;
        end else begin
          m_pos = tgt;
          m_run++;
          m_dir = d;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (started) begin
      check("model p_upper", p_upper, m_pos);
      check("model p_lower", p_lower, m_pos + 60);
      check("model at_top", at_top, m_pos == 165);
      check("model at_bottom", at_bottom, m_pos == 374);
      check("model moving", moving, m_run > 0);
    end

  task automatic tick(input int gap);
    @(negedge clk) frame_tick = 1;
    @(negedge clk) frame_tick = 0;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    started = 1;
    check("reset p_upper", p_upper, 270);
    check("reset moving", moving, 0);
    check("reset at_top", at_top, 0);
    check("reset at_bottom", at_bottom, 0);
    rst = 1;
    repeat (10) tick(1);
    check("idle p_upper", p_upper, 270);
    check("idle p_lower", p_lower, 330);
    check("idle moving", moving, 0);
    move_up = 1;
    for (int i = 0; i < 4; i++) begin
      tick(0);
      check($sformatf("up tick %0d", i), p_upper, 268 - 2 * i);
      repeat (3) @(negedge clk);
      check($sformatf("up hold %0d", i), p_upper, 268 - 2 * i);
    end
    move_up = 0;
    tick(1);
    check("release moving", moving, 0);
    @(negedge clk) recenter = 1;
    @(negedge clk) recenter = 0;
    check("recenter p_upper", p_upper, 270);
    move_down = 1;
    for (int i = 0; i < 12; i++) begin
      tick(0);
      check($sformatf("down tick %0d", i), p_upper, ACCEL ? dn_acc[i] : 272 + 2 * i);
      check($sformatf("down moving %0d", i), moving, 1);
    end
    @(negedge clk) begin recenter = 1; frame_tick = 1; end
    @(negedge clk) begin recenter = 0; frame_tick = 0; end
    check("recenter+tick p_upper", p_upper, 270);
    check("recenter+tick moving", moving, 0);
    repeat (9) tick(0);
    check("hold cleared", p_upper, ACCEL ? 291 : 288);
    repeat (2) tick(0);
    @(negedge clk) begin rst = 0; frame_tick = 1; end
    @(negedge clk) begin rst = 1; frame_tick = 0; end
    check("mid-move rst p_upper", p_upper, 270);
    check("mid-move rst moving", moving, 0);
    move_down = 0;
    move_up = 1;
    n = 0;
    while (!at_top && n < 200) begin tick(0); n++; end
    check("ticks to top", n, ACCEL ? 26 : 53);
    check("top p_upper", p_upper, 165);
    check("top at_top", at_top, 1);
    check("top moving", moving, 0);
    tick(0);
    check("top again p_upper", p_upper, 165);
    check("top again moving", moving, 0);
    move_up = 0;
    move_down = 1;
    n = 0;
    while (!at_bottom && n < 200) begin
      tick(0);
      n++;
      if (ACCEL && n == 46) check("fast at 431", p_lower, 431);
    end
    check("ticks to bottom", n, ACCEL ? 47 : 105);
    check("bottom p_lower", p_lower, 434);
    check("bottom p_upper", p_upper, 374);
    check("bottom moving", moving, 0);
    tick(0);
    check("bottom again p_lower", p_lower, 434);
    check("bottom again moving", moving, 0);
    move_down = 0;
    tick(1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
